// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and instruction-format constants for the fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT, ST_FAULT} state_t;
  localparam logic [7:0] CMD_HALT = 8'hFF;
  localparam int ARGC_W = 2;
  localparam logic [1:0] LEN_MAX = 2'd3;
  // argc 2'b11 is reserved and treated like 2'b10
  function automatic logic [1:0] argc_to_len(input logic [ARGC_W-1:0] argc);
    return (argc == 2'b11) ? LEN_MAX : argc + 2'd1;
  endfunction
endpackage

// File: rtl/fetch_len_decode.sv
// fetch_len_decode: word0 -> instruction length and halt detection, purely combinational.
module fetch_len_decode import fetch_pkg::*; #(
  parameter int WORD_SIZE_ = 32
) (
  input  logic [WORD_SIZE_-1:0] i_word0,
  output logic [1:0]            o_len,
  output logic                  o_is_halt
);
  assign o_len     = argc_to_len(i_word0[WORD_SIZE_-1 -: ARGC_W]);
  assign o_is_halt = i_word0[7:0] == CMD_HALT;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch stage feeding the executor over valid/ready.
// Define FETCH_BOUNDS_EN to fault on fetches that run past the end of the code segment.
module fetch_unit import fetch_pkg::*; #(
  parameter int                    WORD_SIZE_ = 32,
  parameter int                    ADDR_SIZE_ = 32,
  parameter int                    WORDS_NUM_ = 64,
  parameter logic [ADDR_SIZE_-1:0] RESET_PC_  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    redirect_valid,
  input  logic [ADDR_SIZE_-1:0]   redirect_pc,
  output logic [ADDR_SIZE_-1:0]   code_addr,
  input  logic [3*WORD_SIZE_-1:0] code_value,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [WORD_SIZE_-1:0]   instr_cmd,
  output logic [WORD_SIZE_-1:0]   instr_arg0,
  output logic [WORD_SIZE_-1:0]   instr_arg1,
  output logic [1:0]              instr_len,
  output logic [ADDR_SIZE_-1:0]   instr_pc,
  output logic                    halted,
  output logic                    fault
);
`ifdef FETCH_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam int EW = ADDR_SIZE_ + 1;
  state_t                r_state;
  logic [ADDR_SIZE_-1:0] r_pc, r_instr_pc;
  logic [WORD_SIZE_-1:0] r_cmd, r_arg0, r_arg1;
  logic [1:0]            r_len;
  logic                  r_valid, r_halted, r_fault;
  logic [WORD_SIZE_-1:0] w_word0, w_word1, w_word2;
  logic [1:0]            w_len;
  logic                  w_is_halt, w_oob, w_can_cap, w_cap;
  assign {w_word2, w_word1, w_word0} = code_value;
  fetch_len_decode #(.WORD_SIZE_(WORD_SIZE_)) u_len_decode (
    .i_word0  (w_word0),
    .o_len    (w_len),
    .o_is_halt(w_is_halt)
  );
  // last word address computed one bit wider so a wrapping PC is out of range too
  assign w_oob     = BOUNDS_EN && ({1'b0, r_pc} + EW'(w_len) - EW'(1) > EW'(WORDS_NUM_ - 1));
  assign w_can_cap = (r_state == ST_RUN) && (!r_valid || instr_ready);
  assign w_cap     = w_can_cap && !w_oob;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC_;
      r_instr_pc <= '0;
      r_cmd      <= '0;
      r_arg0     <= '0;
      r_arg1     <= '0;
      r_len      <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else if (redirect_valid) begin
      r_state  <= ST_RUN;
      r_pc     <= redirect_pc;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else if (w_cap) begin
      r_valid    <= 1'b1;
      r_instr_pc <= r_pc;
      r_cmd      <= w_word0;
      r_arg0     <= (w_len >= 2'd2) ? w_word1 : '0;
      r_arg1     <= (w_len == LEN_MAX) ? w_word2 : '0;
      r_len      <= w_len;
      r_pc       <= r_pc + ADDR_SIZE_'(w_len);
      if (w_is_halt) begin
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end
    end else begin
      if (instr_ready)
        r_valid <= 1'b0;
      // a blocked capture in RUN can only mean a bounds violation
      if (w_can_cap) begin
        r_state <= ST_FAULT;
        r_fault <= 1'b1;
      end
      if (r_state == ST_IDLE && start)
        r_state <= ST_RUN;
    end
  assign code_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr_cmd   = r_cmd;
  assign instr_arg0  = r_arg0;
  assign instr_arg1  = r_arg1;
  assign instr_len   = r_len;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign fault       = r_fault;
endmodule
